// File: rtl/warp_scheduler_pkg.sv
// Shared types and constants for the warp scheduler and its consumers
// (decoder, fetcher, LSU, register file).
package warp_scheduler_pkg;

    // Default number of warp contexts per core (power of two, at least 2).
    localparam int NUM_WARPS = 4;

    // Per-warp pipeline state broadcast to the rest of the core.
    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

endpackage

// File: rtl/warp_scheduler_if.sv
// Bundle of launch, fetch, decode and LSU handshakes between the core
// and the warp scheduler. The scheduler sits on the slave modport.
interface warp_scheduler_if #(
    parameter int NUM_WARPS  = warp_scheduler_pkg::NUM_WARPS,
    parameter int WARP_IDX_W = $clog2(NUM_WARPS)
) ();

    logic                             start;
    logic [NUM_WARPS-1:0]             warp_active_mask;
    logic                             fetch_done;
    logic                             decoded_mem_read_enable;
    logic                             decoded_mem_write_enable;
    logic                             decoded_halt;
    logic                             decoded_sync;
    logic                             lsu_done;
    warp_scheduler_pkg::warp_state_t  warp_state;
    logic [WARP_IDX_W-1:0]            current_warp;
    logic                             fetch_req;
    logic                             lsu_req;
    logic                             pc_update;
    logic                             done;

    // Core side: launches kernels and answers fetch/decode/LSU handshakes.
    modport master (
        output start, warp_active_mask, fetch_done,
               decoded_mem_read_enable, decoded_mem_write_enable,
               decoded_halt, decoded_sync, lsu_done,
        input  warp_state, current_warp, fetch_req, lsu_req, pc_update, done
    );

    // Scheduler side.
    modport slave (
        input  start, warp_active_mask, fetch_done,
               decoded_mem_read_enable, decoded_mem_write_enable,
               decoded_halt, decoded_sync, lsu_done,
        output warp_state, current_warp, fetch_req, lsu_req, pc_update, done
    );

endinterface

// File: rtl/warp_scheduler_rr_next_warp.sv
// Round-robin picker: first set bit of i_eligible strictly after
// i_current_warp, wrapping around (so i_current_warp itself comes last).
module rr_next_warp #(
    parameter int NUM_WARPS  = 4,
    parameter int WARP_IDX_W = $clog2(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0]  i_eligible,
    input  logic [WARP_IDX_W-1:0] i_current_warp,
    output logic [WARP_IDX_W-1:0] o_next_warp,
    output logic                  o_valid
);

    logic [WARP_IDX_W-1:0] w_idx;

    // Scan offsets 1..NUM_WARPS; index arithmetic wraps by truncation.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        o_next_warp = i_current_warp;
        o_valid     = 1'b0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            w_idx = i_current_warp + WARP_IDX_W'(k);
            if (!o_valid && i_eligible[w_idx]) begin
                o_next_warp = w_idx;
                o_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: walks one warp at a time through
// fetch/decode/request/wait/execute/update, rotates round-robin between
// live warps, retires warps on HALT and implements SYNC as a barrier over
// all live warps.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS  = warp_scheduler_pkg::NUM_WARPS,
    parameter int WARP_IDX_W = $clog2(NUM_WARPS)
) (
    input  logic            clk,
    input  logic            reset,
    warp_scheduler_if.slave bus
);

    warp_state_t           r_state,        w_state_next;
    logic [WARP_IDX_W-1:0] r_current_warp, w_warp_next;
    logic [NUM_WARPS-1:0]  r_active,       w_active_next;
    logic [NUM_WARPS-1:0]  r_halted,       w_halted_next;
    logic [NUM_WARPS-1:0]  r_at_barrier,   w_barrier_next;
    // Warps still owed a pc_update pulse during a barrier release.
    logic [NUM_WARPS-1:0]  r_release,      w_release_next;
    logic                  r_done,         w_done_next;
    logic                  r_fetch_req;
    logic                  r_pc_update;

    logic                  w_idle_like;
    logic                  w_req_halt;
    logic                  w_req_sync;
    logic                  w_lsu_req;
    logic                  w_schedule;
    logic [NUM_WARPS-1:0]  w_cur_onehot;
    logic [NUM_WARPS-1:0]  w_halted_upd;
    logic [NUM_WARPS-1:0]  w_barrier_upd;
    logic [NUM_WARPS-1:0]  w_eligible;
    logic [NUM_WARPS-1:0]  w_first_src;
    logic [NUM_WARPS-1:0]  w_first_onehot;
    logic [WARP_IDX_W-1:0] w_rr_idx;
    logic [WARP_IDX_W-1:0] w_first_idx;
    logic                  w_rr_valid;
    logic                  w_first_valid;

    // Masks as they will be after this cycle's REQUEST decision, so the
    // scheduler never picks a warp that is halting or entering the barrier.
    assign w_idle_like    = (r_state == WARP_IDLE) || (r_state == WARP_DONE);
    assign w_cur_onehot   = NUM_WARPS'(1) << r_current_warp;
    assign w_req_halt     = (r_state == WARP_REQUEST) && bus.decoded_halt;
    assign w_req_sync     = (r_state == WARP_REQUEST) && !bus.decoded_halt && bus.decoded_sync;
    assign w_halted_upd   = r_halted     | (w_req_halt ? w_cur_onehot : '0);
    assign w_barrier_upd  = r_at_barrier | (w_req_sync ? w_cur_onehot : '0);
    assign w_eligible     = r_active & ~w_halted_upd & ~w_barrier_upd;

    // Lowest-set-bit source: launch mask, pending release set, or the
    // barrier set about to be released.
    assign w_first_src    = w_idle_like         ? bus.warp_active_mask :
                            (r_release != '0)   ? r_release            :
                                                  w_barrier_upd;
    assign w_first_onehot = NUM_WARPS'(1) << w_first_idx;

    rr_next_warp #(.NUM_WARPS(NUM_WARPS), .WARP_IDX_W(WARP_IDX_W)) u_rr_sched (
        .i_eligible     (w_eligible),
        .i_current_warp (r_current_warp),
        .o_next_warp    (w_rr_idx),
        .o_valid        (w_rr_valid)
    );

    // Starting the scan after the top index yields the lowest set bit.
    rr_next_warp #(.NUM_WARPS(NUM_WARPS), .WARP_IDX_W(WARP_IDX_W)) u_rr_first (
        .i_eligible     (w_first_src),
        .i_current_warp (WARP_IDX_W'(NUM_WARPS - 1)),
        .o_next_warp    (w_first_idx),
        .o_valid        (w_first_valid)
    );

    // Next-state, mask updates and the REQUEST-cycle lsu_req pulse.
    always_comb begin
        w_state_next   = r_state;
        w_warp_next    = r_current_warp;
        w_active_next  = r_active;
        w_halted_next  = w_halted_upd;
        w_barrier_next = w_barrier_upd;
        w_release_next = r_release;
        w_done_next    = r_done;
        w_lsu_req      = 1'b0;
        w_schedule     = 1'b0;

        unique case (r_state)
            WARP_IDLE, WARP_DONE: begin
                if (bus.start) begin
                    w_active_next  = bus.warp_active_mask;
                    w_halted_next  = '0;
                    w_barrier_next = '0;
                    w_release_next = '0;
                    if (w_first_valid) begin
                        w_warp_next  = w_first_idx;
                        w_state_next = WARP_FETCH;
                        w_done_next  = 1'b0;
                    end else begin
                        // Empty launch: nothing to run, completion is immediate.
                        w_state_next = WARP_DONE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            WARP_FETCH: begin
                if (bus.fetch_done) w_state_next = WARP_DECODE;
            end
            WARP_DECODE: begin
                w_state_next = WARP_REQUEST;
            end
            WARP_REQUEST: begin
                if (bus.decoded_halt || bus.decoded_sync) begin
                    w_schedule = 1'b1;
                end else if (bus.decoded_mem_read_enable || bus.decoded_mem_write_enable) begin
                    w_lsu_req    = 1'b1;
                    w_state_next = WARP_WAIT;
                end else begin
                    w_state_next = WARP_EXECUTE;
                end
            end
            WARP_WAIT: begin
                if (bus.lsu_done) w_state_next = WARP_EXECUTE;
            end
            WARP_EXECUTE: begin
                w_state_next = WARP_UPDATE;
            end
            WARP_UPDATE: begin
                if (r_release != '0) begin
                    // One released warp per cycle, ascending index.
                    w_warp_next    = w_first_idx;
                    w_release_next = r_release & ~w_first_onehot;
                end else begin
                    w_schedule = 1'b1;
                end
            end
            default: w_state_next = WARP_IDLE;
        endcase

        if (w_schedule) begin
            if (w_rr_valid) begin
                w_warp_next  = w_rr_idx;
                w_state_next = WARP_FETCH;
            end else if (w_first_valid) begin
                // Every live warp is parked at the barrier: release them all.
                w_warp_next    = w_first_idx;
                w_release_next = w_barrier_upd & ~w_first_onehot;
                w_barrier_next = '0;
                w_state_next   = WARP_UPDATE;
            end else begin
                w_state_next = WARP_DONE;
                w_done_next  = 1'b1;
            end
        end
    end

    // State, masks and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= WARP_IDLE;
            r_current_warp <= '0;
            r_active       <= '0;
            r_halted       <= '0;
            r_at_barrier   <= '0;
            r_release      <= '0;
            r_done         <= 1'b0;
            r_fetch_req    <= 1'b0;
            r_pc_update    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // values from before this edge, independent of statement order.
            r_state        <= w_state_next;
            r_current_warp <= w_warp_next;
            r_active       <= w_active_next;
            r_halted       <= w_halted_next;
            r_at_barrier   <= w_barrier_next;
            r_release      <= w_release_next;
            r_done         <= w_done_next;
            r_fetch_req    <= (w_state_next == WARP_FETCH);
            r_pc_update    <= (w_state_next == WARP_UPDATE);
        end
    end

    assign bus.warp_state   = r_state;
    assign bus.current_warp = r_current_warp;
    assign bus.fetch_req    = r_fetch_req;
    assign bus.lsu_req      = w_lsu_req;
    assign bus.pc_update    = r_pc_update;
    assign bus.done         = r_done;

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler. An instruction-level model expands
// per-warp instruction streams into an expected per-cycle trace (state, warp,
// output pulses) together with the stimulus for that cycle; the DUT is
// driven from the trace and compared every cycle.
module tb_warp_scheduler;
    import warp_scheduler_pkg::*;

    localparam int NW = 4;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_SYNC, K_HALT} kind_e;
    typedef enum int {M_RANDOM, M_ALU, M_LOAD_HALT, M_SYNC_HALT, M_HALT} mode_e;

    typedef struct {
        warp_state_t st;
        logic [1:0]  warp;
        logic        chk_warp;
        logic        lsu;
        logic        start;
        logic [3:0]  mask;
        logic        fetch_done;
        logic        lsu_done;
        logic        halt;
        logic        sync;
        logic        rd;
        logic        wr;
    } cyc_t;

    cyc_t tr[$];
    int   errors = 0;
    int   checks = 0;
    int   shown  = 0;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    warp_scheduler_if #(.NUM_WARPS(NW)) bus ();

    warp_scheduler #(.NUM_WARPS(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------

    function automatic int next_after(input logic [3:0] m, input int cur);
        for (int s = 1; s <= NW; s++)
            if (m[(cur + s) % NW]) return (cur + s) % NW;
        return cur;
    endfunction

    // One cycle of the expected trace; inputs that the DUT must ignore in
    // this state are randomised.
    function automatic cyc_t mk(input warp_state_t st, input int w);
        cyc_t c;
        c.st         = st;
        c.warp       = 2'(w);
        c.chk_warp   = (st != WARP_IDLE) && (st != WARP_DONE);
        c.lsu        = 1'b0;
        c.start      = c.chk_warp ? 1'($urandom) : 1'b0;
        c.mask       = 4'($urandom);
        c.fetch_done = 1'($urandom);
        c.lsu_done   = 1'($urandom);
        c.halt       = 1'($urandom);
        c.sync       = 1'($urandom);
        c.rd         = 1'($urandom);
        c.wr         = 1'($urandom);
        return c;
    endfunction

    task automatic pick(input mode_e mode, input int n, output kind_e k, output int fd, output int ld);
        int r;
        fd = 0;
        ld = 0;
        case (mode)
            M_ALU:       k = K_ALU;
            M_LOAD_HALT: begin k = (n == 0) ? K_LOAD : K_HALT; ld = 3; end
            M_SYNC_HALT: k = (n == 0) ? K_SYNC : K_HALT;
            M_HALT:      k = K_HALT;
            default: begin
                fd = $urandom_range(0, 3);
                ld = $urandom_range(0, 4);
                r  = $urandom_range(0, 9);
                if (n >= 8)      k = K_HALT;
                else if (r < 4)  k = K_ALU;
                else if (r < 6)  k = K_LOAD;
                else if (r < 7)  k = K_STORE;
                else if (r < 9)  k = K_SYNC;
                else             k = K_HALT;
            end
        endcase
    endtask

    task automatic build(input logic [3:0] mask, input mode_e mode, input int max_len,
                         input warp_state_t prev);
        logic [3:0] active, halted, barrier, elig;
        int    cur, fd, ld;
        int    cnt[NW];
        kind_e k;
        cyc_t  c;
        bit    fin;
        tr.delete();
        c = mk(prev, 0);
        c.start = 1'b1;
        c.mask  = mask;
        tr.push_back(c);
        if (mask == 4'b0000) begin
            repeat (3) tr.push_back(mk(WARP_DONE, 0));
            return;
        end
        active  = mask;
        halted  = '0;
        barrier = '0;
        cur     = next_after(mask, NW - 1);
        for (int w = 0; w < NW; w++) cnt[w] = 0;
        fin = 1'b0;
        while (!fin && tr.size() < max_len) begin
            pick(mode, cnt[cur], k, fd, ld);
            cnt[cur]++;
            for (int j = 0; j <= fd; j++) begin
                c = mk(WARP_FETCH, cur);
                c.fetch_done = (j == fd);
                tr.push_back(c);
            end
            tr.push_back(mk(WARP_DECODE, cur));
            c = mk(WARP_REQUEST, cur);
            c.halt = (k == K_HALT);
            if (k != K_HALT) c.sync = (k == K_SYNC);
            if (k != K_HALT && k != K_SYNC) begin
                c.rd = (k == K_LOAD);
                c.wr = (k == K_STORE);
            end
            c.lsu = (k == K_LOAD) || (k == K_STORE);
            tr.push_back(c);
            case (k)
                K_HALT: halted[cur]  = 1'b1;
                K_SYNC: barrier[cur] = 1'b1;
                default: begin
                    if (k != K_ALU)
                        for (int j = 0; j <= ld; j++) begin
                            c = mk(WARP_WAIT, cur);
                            c.lsu_done = (j == ld);
                            tr.push_back(c);
                        end
                    tr.push_back(mk(WARP_EXECUTE, cur));
                    tr.push_back(mk(WARP_UPDATE, cur));
                end
            endcase
            elig = active & ~halted & ~barrier;
            if (elig == '0 && barrier != '0) begin
                for (int w = 0; w < NW; w++)
                    if (barrier[w]) begin
                        tr.push_back(mk(WARP_UPDATE, w));
                        cur = w;
                    end
                barrier = '0;
                elig    = active & ~halted;
            end
            if (elig != '0) begin
                cur = next_after(elig, cur);
            end else begin
                repeat (3) tr.push_back(mk(WARP_DONE, cur));
                fin = 1'b1;
            end
        end
    endtask

    // ---------------- stimulus / comparison ----------------

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.warp_active_mask = '0;
        bus.fetch_done = 1'b0;
        bus.lsu_done = 1'b0;
        bus.decoded_halt = 1'b0;
        bus.decoded_sync = 1'b0;
        bus.decoded_mem_read_enable = 1'b0;
        bus.decoded_mem_write_enable = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_trace(input string name, input int limit);
        int   n;
        cyc_t e;
        n = (limit < 0 || limit > tr.size()) ? tr.size() : limit;
        for (int i = 0; i < n; i++) begin
            e = tr[i];
            @(posedge clk);
            #1;
            bus.start = e.start;
            bus.warp_active_mask = e.mask;
            bus.fetch_done = e.fetch_done;
            bus.lsu_done = e.lsu_done;
            bus.decoded_halt = e.halt;
            bus.decoded_sync = e.sync;
            bus.decoded_mem_read_enable = e.rd;
            bus.decoded_mem_write_enable = e.wr;
            @(negedge clk);
            checks++;
            if (bus.warp_state !== e.st) begin
                errors++;
                if (shown++ < 30) $display("FAIL %s cyc%0d warp_state: got %0d want %0d", name, i, bus.warp_state, e.st);
            end
            if (e.chk_warp) begin
                checks++;
                if (bus.current_warp !== e.warp) begin
                    errors++;
                    if (shown++ < 30) $display("FAIL %s cyc%0d current_warp: got %0d want %0d", name, i, bus.current_warp, e.warp);
                end
            end
            checks++;
            if (bus.fetch_req !== (e.st == WARP_FETCH)) begin
                errors++;
                if (shown++ < 30) $display("FAIL %s cyc%0d fetch_req: got %b want %b", name, i, bus.fetch_req, e.st == WARP_FETCH);
            end
            checks++;
            if (bus.lsu_req !== e.lsu) begin
                errors++;
                if (shown++ < 30) $display("FAIL %s cyc%0d lsu_req: got %b want %b", name, i, bus.lsu_req, e.lsu);
            end
            checks++;
            if (bus.pc_update !== (e.st == WARP_UPDATE)) begin
                errors++;
                if (shown++ < 30) $display("FAIL %s cyc%0d pc_update: got %b want %b", name, i, bus.pc_update, e.st == WARP_UPDATE);
            end
            checks++;
            if (bus.done !== (e.st == WARP_DONE)) begin
                errors++;
                if (shown++ < 30) $display("FAIL %s cyc%0d done: got %b want %b", name, i, bus.done, e.st == WARP_DONE);
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (bus.warp_state !== WARP_IDLE || bus.current_warp !== 2'd0) begin
            errors++;
            $display("FAIL %s state/warp: got %0d/%0d want %0d/0", name, bus.warp_state, bus.current_warp, WARP_IDLE);
        end
        checks++;
        if ({bus.fetch_req, bus.lsu_req, bus.pc_update, bus.done} !== 4'b0000) begin
            errors++;
            $display("FAIL %s outputs fetch/lsu/pc/done: got %b want 0000", name,
                     {bus.fetch_req, bus.lsu_req, bus.pc_update, bus.done});
        end
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        bus.start = 1'b1;
        bus.warp_active_mask = 4'b1111;
        bus.fetch_done = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset_held");
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        check_quiet("reset_released");
    endtask

    task automatic test_single_alu();
        apply_reset();
        build(4'b0001, M_ALU, 31, WARP_IDLE);
        run_trace("single_alu", -1);
    endtask

    task automatic test_round_robin();
        apply_reset();
        build(4'b1011, M_ALU, 40, WARP_IDLE);
        run_trace("round_robin", -1);
    endtask

    task automatic test_load_latency();
        apply_reset();
        build(4'b0001, M_LOAD_HALT, 100, WARP_IDLE);
        run_trace("load_latency", -1);
    endtask

    task automatic test_barrier();
        apply_reset();
        build(4'b0011, M_SYNC_HALT, 100, WARP_IDLE);
        run_trace("barrier", -1);
    endtask

    task automatic test_completion();
        apply_reset();
        build(4'b0101, M_HALT, 100, WARP_IDLE);
        run_trace("completion", -1);
        build(4'b0000, M_HALT, 100, WARP_DONE);
        run_trace("restart_empty", -1);
        build(4'b0110, M_RANDOM, 5000, WARP_DONE);
        run_trace("restart_live", -1);
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        build(4'b0001, M_LOAD_HALT, 100, WARP_IDLE);
        // IDLE, FETCH, DECODE, REQUEST, WAIT, WAIT; the trailing edge enters a third WAIT.
        run_trace("mid_wait_pre", 6);
        #1;
        reset = 1'b0;
        bus.lsu_done = 1'b1;
        #1;
        check_quiet("mid_wait_async");
        @(negedge clk);
        check_quiet("mid_wait_edge");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("late_lsu_done");
        end
        idle_inputs();
    endtask

    task automatic test_random();
        warp_state_t prev;
        apply_reset();
        prev = WARP_IDLE;
        for (int it = 0; it < 15; it++) begin
            build(4'($urandom_range(0, 15)), M_RANDOM, 5000, prev);
            run_trace($sformatf("random%0d", it), -1);
            prev = WARP_DONE;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_alu();
        test_round_robin();
        test_load_latency();
        test_barrier();
        test_completion();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
